// File: rtl/seven_seg_to_hex_reader.sv
// Seven-segment display reader: samples a multiplexed 4-digit 7-segment bus,
// debounces each digit strobe, decodes the segment pattern to a hex nibble and
// assembles complete 4-digit frames.
//
// Ports:
//   clk         - sole clock, rising edge
//   reset       - synchronous active-high reset
//   seg[6:0]    - segments: 0 top, 1 upper-right, 2 lower-right, 3 bottom,
//                 4 lower-left, 5 upper-left, 6 middle
//   dig_en[3:0] - digit strobes, bit i selects hex digit i (bit 3 = MS nibble)
//   hex_value   - last complete decoded frame
//   frame_valid - one-cycle pulse when hex_value updates
//   frame_err   - 1 = at least one digit of the frame was an unknown pattern
//   digit_mask  - digits captured so far in the current frame
module seven_seg_to_hex_reader #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_en,
  output logic [15:0] hex_value,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [3:0]  digit_mask
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t           state, state_n;
  logic [3:0]       count, count_n;
  logic [6:0]       seg_q;
  logic [3:0]       dig_q;
  logic [10:0]      prev_q;
  logic [3:0][3:0]  nib, nib_new;
  logic [3:0]       err_bits, err_new;
  logic [3:0]       mask_new;
  logic [3:0]       dec_nib;
  logic             dec_err;
  logic             one_hot;
  logic             changed;
  logic             capture;

  assign one_hot  = (dig_q != 4'b0000) && ((dig_q & (dig_q - 4'd1)) == 4'b0000);
  assign changed  = ({dig_q, seg_q} != prev_q);
  assign mask_new = digit_mask | dig_q;

  always_comb begin
    dec_nib = 4'h0;
    dec_err = 1'b0;
    case (seg_q)
      7'b0111111: dec_nib = 4'h0;
      7'b0000110: dec_nib = 4'h1;
      7'b1011011: dec_nib = 4'h2;
      7'b1001111: dec_nib = 4'h3;
      7'b1100110: dec_nib = 4'h4;
      7'b1101101: dec_nib = 4'h5;
      7'b1111101: dec_nib = 4'h6;
      7'b0000111: dec_nib = 4'h7;
      7'b1111111: dec_nib = 4'h8;
      7'b1101111: dec_nib = 4'h9;
      7'b1110111: dec_nib = 4'hA;
      7'b1111100: dec_nib = 4'hB;
      7'b0111001: dec_nib = 4'hC;
      7'b1011110: dec_nib = 4'hD;
      7'b1111001: dec_nib = 4'hE;
      7'b1110001: dec_nib = 4'hF;
      default: begin
        dec_nib = 4'h0;
        dec_err = 1'b1;
      end
    endcase
  end

  // dig_q is one-hot whenever capture fires, so only the strobed slot changes.
  always_comb begin
    nib_new = nib;
    err_new = err_bits;
    for (int unsigned i = 0; i < 4; i++) begin
      if (dig_q[i]) begin
        nib_new[i] = dec_nib;
        err_new[i] = dec_err;
      end
    end
  end

  // Next count is computed first; reaching STABLE_N on any path into SETTLE
  // (including straight from IDLE/HOLD with count 1) captures and enters HOLD.
  always_comb begin
    state_n = state;
    count_n = count;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (one_hot) begin
          state_n = SETTLE;
          count_n = 4'd1;
        end
      end
      SETTLE: begin
        if (!one_hot) begin
          state_n = IDLE;
          count_n = '0;
        end else if (changed) begin
          count_n = 4'd1;
        end else begin
          count_n = count + 4'd1;
        end
      end
      HOLD: begin
        if (changed) begin
          if (!one_hot) begin
            state_n = IDLE;
            count_n = '0;
          end else begin
            state_n = SETTLE;
            count_n = 4'd1;
          end
        end else if (count != '1) begin
          count_n = count + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
    if (state_n == SETTLE && count_n >= STABLE_N) begin
      capture = 1'b1;
      state_n = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      seg_q       <= '0;
      dig_q       <= '0;
      prev_q      <= '0;
      nib         <= '0;
      err_bits    <= '0;
      hex_value   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      digit_mask  <= '0;
    end else begin
      seg_q       <= ACTIVE_LOW ? ~seg : seg;
      dig_q       <= ACTIVE_LOW ? ~dig_en : dig_en;
      prev_q      <= {dig_q, seg_q};
      state       <= state_n;
      count       <= count_n;
      frame_valid <= 1'b0;
      if (capture) begin
        nib      <= nib_new;
        err_bits <= err_new;
        if (mask_new == 4'b1111) begin
          hex_value   <= nib_new;
          frame_err   <= |err_new;
          frame_valid <= 1'b1;
          digit_mask  <= '0;
        end else begin
          digit_mask  <= mask_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_to_hex_reader.sv
// Bench for seven_seg_to_hex_reader: an active-high and an active-low instance
// see the same (inverted) stimulus; expected frames are queued per instance and
// a negedge monitor pops and compares on every frame_valid.
module tb_seven_seg_to_hex_reader;

  localparam logic [6:0] P0 = 7'b0111111, P1 = 7'b0000110, P2 = 7'b1011011,
                         P3 = 7'b1001111, P4 = 7'b1100110, P5 = 7'b1101101,
                         P6 = 7'b1111101, P7 = 7'b0000111, P8 = 7'b1111111,
                         P9 = 7'b1101111, PA = 7'b1110111, PB = 7'b1111100,
                         PC = 7'b0111001, PD = 7'b1011110, PE = 7'b1111001,
                         PF = 7'b1110001, PX = 7'b0000001;

  typedef struct packed {
    logic [15:0] hex;
    logic        err;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic [6:0]  seg_n;
  logic [3:0]  dig_en_n;
  logic [15:0] hi_hex, lo_hex;
  logic        hi_valid, lo_valid, hi_err, lo_err;
  logic [3:0]  hi_mask, lo_mask;

  int checks   = 0;
  int failures = 0;
  frame_t exp_hi[$];
  frame_t exp_lo[$];

  assign seg_n    = ~seg;
  assign dig_en_n = ~dig_en;

  always #5 clk = ~clk;

  seven_seg_to_hex_reader #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .reset(reset), .seg(seg), .dig_en(dig_en),
    .hex_value(hi_hex), .frame_valid(hi_valid), .frame_err(hi_err),
    .digit_mask(hi_mask)
  );

  seven_seg_to_hex_reader #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .reset(reset), .seg(seg_n), .dig_en(dig_en_n),
    .hex_value(lo_hex), .frame_valid(lo_valid), .frame_err(lo_err),
    .digit_mask(lo_mask)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] hex, input logic err);
    frame_t f;
    f.hex = hex;
    f.err = err;
    exp_hi.push_back(f);
    exp_lo.push_back(f);
  endtask

  // Present one strobe for n edges; check digit_mask one edge before and at
  // the expected capture edge (cap = 0 disables the timing checks).
  task automatic strobe(input logic [3:0] d, input logic [6:0] s, input int n,
                        input int cap, input logic [3:0] m_pre, input logic [3:0] m_post);
    dig_en = d;
    seg    = s;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (k == cap - 1) begin
        chk("mask_pre_hi", 32'(hi_mask), 32'(m_pre));
        chk("mask_pre_lo", 32'(lo_mask), 32'(m_pre));
      end
      if (k == cap) begin
        chk("mask_cap_hi", 32'(hi_mask), 32'(m_post));
        chk("mask_cap_lo", 32'(lo_mask), 32'(m_post));
      end
    end
  endtask

  task automatic idle(input int n);
    strobe(4'b0000, 7'b0000000, n, 0, 4'b0000, 4'b0000);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_hex_hi"},  32'(hi_hex),   32'h0);
    chk({tag, "_hex_lo"},  32'(lo_hex),   32'h0);
    chk({tag, "_mask_hi"}, 32'(hi_mask),  32'h0);
    chk({tag, "_mask_lo"}, 32'(lo_mask),  32'h0);
    chk({tag, "_err_hi"},  32'(hi_err),   32'h0);
    chk({tag, "_fv_hi"},   32'(hi_valid), 32'h0);
  endtask

  always @(negedge clk) begin : monitor
    frame_t f;
    if (hi_valid === 1'b1) begin
      if (exp_hi.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL frame_hi_unexpected actual=%0h required=none", hi_hex);
      end else begin
        f = exp_hi.pop_front();
        chk("frame_hi_hex", 32'(hi_hex), 32'(f.hex));
        chk("frame_hi_err", 32'(hi_err), 32'(f.err));
      end
    end
    if (lo_valid === 1'b1) begin
      if (exp_lo.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL frame_lo_unexpected actual=%0h required=none", lo_hex);
      end else begin
        f = exp_lo.pop_front();
        chk("frame_lo_hex", 32'(lo_hex), 32'(f.hex));
        chk("frame_lo_err", 32'(lo_err), 32'(f.err));
      end
    end
  end

  initial begin
    reset  = 1'b1;
    seg    = '0;
    dig_en = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_cleared("reset");
    idle(2);

    // Scan: 1,2,A,F on digits 3..0, capture on the 5th edge of each strobe.
    push_frame(16'h12AF, 1'b0);
    strobe(4'b1000, P1, 6, 5, 4'b0000, 4'b1000);
    strobe(4'b0100, P2, 6, 5, 4'b1000, 4'b1100);
    strobe(4'b0010, PA, 6, 5, 4'b1100, 4'b1110);
    strobe(4'b0001, PF, 6, 5, 4'b1110, 4'b0000);
    idle(3);

    // Glitch: "0" for 3 cycles then "1" for 5; only "1" lands in slot 0.
    push_frame(16'h5671, 1'b0);
    strobe(4'b0001, P0, 3, 0, 4'b0000, 4'b0000);
    strobe(4'b0001, P1, 5, 5, 4'b0000, 4'b0001);
    idle(2);
    chk("hex_hold_hi", 32'(hi_hex), 32'h12AF);
    strobe(4'b1000, P5, 6, 5, 4'b0001, 4'b1001);
    strobe(4'b0100, P6, 6, 5, 4'b1001, 4'b1101);
    strobe(4'b0010, P7, 6, 5, 4'b1101, 4'b0000);
    idle(3);

    // Unknown pattern on digit 2, digits delivered in 0..3 order.
    push_frame(16'h7034, 1'b1);
    strobe(4'b0001, P4, 6, 5, 4'b0000, 4'b0001);
    strobe(4'b0010, P3, 6, 5, 4'b0001, 4'b0011);
    strobe(4'b0100, PX, 6, 5, 4'b0011, 4'b0111);
    strobe(4'b1000, P7, 6, 5, 4'b0111, 4'b0000);
    idle(3);

    // Strobe faults leave the partial mask untouched.
    push_frame(16'hDCBE, 1'b0);
    strobe(4'b0001, PE, 6, 5, 4'b0000, 4'b0001);
    strobe(4'b0101, P8, 10, 0, 4'b0000, 4'b0000);
    chk("fault_multi_mask_hi", 32'(hi_mask), 32'h1);
    chk("fault_multi_mask_lo", 32'(lo_mask), 32'h1);
    strobe(4'b0000, P8, 10, 0, 4'b0000, 4'b0000);
    chk("fault_zero_mask_hi", 32'(hi_mask), 32'h1);
    strobe(4'b0010, PB, 6, 5, 4'b0001, 4'b0011);
    strobe(4'b0100, PC, 6, 5, 4'b0011, 4'b0111);
    strobe(4'b1000, PD, 6, 5, 4'b0111, 4'b0000);
    idle(3);

    // Long hold then re-capture of digit 0: latest value wins.
    push_frame(16'h0089, 1'b0);
    strobe(4'b0001, P3, 30, 5, 4'b0000, 4'b0001);
    strobe(4'b0001, P9, 6, 5, 4'b0001, 4'b0001);
    strobe(4'b0010, P8, 6, 5, 4'b0001, 4'b0011);
    strobe(4'b0100, P0, 6, 5, 4'b0011, 4'b0111);
    strobe(4'b1000, P0, 6, 5, 4'b0111, 4'b0000);
    idle(3);

    // Reset after three captures discards the partial frame.
    strobe(4'b1000, P1, 6, 5, 4'b0000, 4'b1000);
    strobe(4'b0100, P2, 6, 5, 4'b1000, 4'b1100);
    strobe(4'b0010, P3, 6, 5, 4'b1100, 4'b1110);
    idle(2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_cleared("midreset");
    push_frame(16'h7654, 1'b0);
    strobe(4'b0001, P4, 6, 5, 4'b0000, 4'b0001);
    strobe(4'b0010, P5, 6, 5, 4'b0001, 4'b0011);
    strobe(4'b0100, P6, 6, 5, 4'b0011, 4'b0111);
    strobe(4'b1000, P7, 6, 5, 4'b0111, 4'b0000);
    idle(5);

    chk("pending_frames_hi", 32'(exp_hi.size()), 32'h0);
    chk("pending_frames_lo", 32'(exp_lo.size()), 32'h0);
    chk("final_hex_hi", 32'(hi_hex), 32'h7654);
    chk("final_hex_lo", 32'(lo_hex), 32'h7654);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_to_hex_reader.md
SEVEN_SEG_TO_HEX_READER -- requirements
Module: seven_seg_to_hex_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4 (range 1-15): consecutive identical samples required before a digit is accepted.
REQ-002 SHALL have parameter ACTIVE_LOW, default 0: 1 = seg and dig_en are inverted at the input register before any other logic.
REQ-003 SHALL have port clk, input, 1, the only clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port seg, input, 7, segment bus in the order bit0 top, bit1 upper-right, bit2 lower-right, bit3 bottom, bit4 lower-left, bit5 upper-left, bit6 middle.
REQ-006 SHALL have port dig_en, input, 4, digit strobes of a multiplexed display; bit i selects hex digit i, and bit 3 is the most significant nibble.
REQ-007 SHALL have port hex_value, output, 16, last complete decoded 4-digit frame.
REQ-008 SHALL have port frame_valid, output, 1, one-cycle pulse when hex_value updates.
REQ-009 SHALL have port frame_err, output, 1, qualifies hex_value; 1 = at least one digit in the frame was an unknown pattern.
REQ-010 SHALL have port digit_mask, output, 4, digits captured so far in the current frame.

Function
REQ-011 seg and dig_en SHALL be registered once (input stage), including any ACTIVE_LOW inversion; all other decisions use these registered copies.
REQ-012 The pattern table SHALL be (bit6..bit0): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-013 Any other pattern, including all-off 0000000, SHALL decode to nibble 0 with the digit error bit set.
REQ-014 The FSM SHALL have states IDLE, SETTLE and HOLD.
REQ-015 IDLE: registered dig_en is not one-hot (zero or multiple bits). Stay in IDLE. Go to SETTLE with stable count=1 when dig_en becomes one-hot.
REQ-016 SETTLE: each cycle where registered {dig_en, seg} equals the previous cycle's value SHALL increment the count.
REQ-017 SETTLE: any change in {dig_en, seg} SHALL restart the count at 1, or go to IDLE if dig_en is no longer one-hot.
REQ-018 SETTLE: on the edge where the count would reach STABLE_CYCLES, the digit SHALL be captured into nibble slot i and the FSM SHALL go to HOLD.
REQ-019 With STABLE_CYCLES=1, capture SHALL occur on the first edge after the input register, with no counting.
REQ-020 HOLD: no further capture SHALL occur. Any change in {dig_en, seg} SHALL go to SETTLE (count=1), or to IDLE if dig_en is not one-hot.
REQ-021 Capture latency SHALL be STABLE_CYCLES+1 rising edges from the first edge at which the stable value is present on the ports.
REQ-022 Capture SHALL set digit_mask[i] and store the nibble and error bit. Re-capturing a digit already in digit_mask SHALL overwrite it (latest wins) and SHALL NOT complete a frame.
REQ-023 When a capture makes digit_mask 1111, on the same edge:
- hex_value SHALL load the four stored nibbles (new digit included);
- frame_err SHALL load the OR of the four error bits;
- frame_valid SHALL be 1 for exactly one cycle;
- digit_mask SHALL clear to 0000.
REQ-024 hex_value and frame_err SHALL hold their values between frame completions.
REQ-025 The stability count SHALL saturate, and SHALL NOT wrap, while in HOLD.
REQ-026 Digit captures SHALL be accepted in any order.

Reset
REQ-027 When reset=1 at a rising edge:
- FSM SHALL go to IDLE with count 0;
- input registers, stored nibbles and error bits SHALL clear;
- outputs SHALL be hex_value=0000, frame_valid=0, frame_err=0, digit_mask=0000.
REQ-028 Reset SHALL take priority over a simultaneous capture or frame completion. A partially captured frame SHALL be discarded, and the first frame after reset SHALL need all four digits again.

Verification
REQ-029 Scan test, STABLE_CYCLES=4: strobe digits 3..0 for 6 cycles each with patterns 1, 2, A, F -> one frame_valid, hex_value=0x12AF, frame_err=0; each capture occurs 5 edges after its strobe starts.
REQ-030 Glitch test: digit 0 shows 0111111 for 3 cycles, then 0000110 for 5 cycles -> only "1" is captured; the "0" is never captured.
REQ-031 Unknown pattern test: digit 2 carries 0000001 within an otherwise valid frame of 7, ?, 3, 4 -> hex_value=0x7034, frame_err=1, one frame_valid pulse.
REQ-032 Strobe fault test: dig_en=0101 or 0000 for 10 cycles -> no capture and digit_mask unchanged; a one-hot strobe afterwards is captured normally.
REQ-033 Reset mid-frame test: reset after 3 digits are captured -> digit_mask=0000 and hex_value=0000; the next frame needs all 4 digits; no frame_valid pulse from the old partial frame.
REQ-034 ACTIVE_LOW=1 test: apply inverted versions of the REQ-029 stimulus -> identical hex_value=0x12AF and identical timing.
